alu_operand_stack: RTL

//  Data-stack controller that drives the stack processor's combinational ALU (Oper/A/B in, result out).
//  It accepts push/pop/ALU commands, pops the two topmost operands and presents them to the ALU.
//  It then writes the ALU result back as the new top of stack.

---
 rtl/alu_operand_stack.sv | 112 +++++++++++
 1 files changed

// File: rtl/alu_operand_stack.sv
// rtl/alu_operand_stack.sv - data stack that feeds a combinational ALU and writes its result back
module alu_operand_stack #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int PTRW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic [3:0]       cmd_oper,
  input  logic [WIDTH-1:0] push_data,
  output logic [3:0]       alu_oper,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] top,
  output logic [PTRW-1:0]  count,
  output logic             done,
  output logic             err_overflow,
  output logic             err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] C_NOP = 2'b00, C_PUSH = 2'b01, C_POP = 2'b10, C_ALU = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_count;
  logic [3:0]       r_oper;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_done, r_ovf, r_unf;

  logic            w_accept, w_full, w_empty, w_two;
  logic            w_push_ok, w_push_err, w_pop_ok, w_pop_err, w_alu_ok, w_alu_err, w_wb;
  logic [AW-1:0]   w_idx_wr, w_idx_top, w_idx_next;

  // Index arithmetic wraps in AW bits, so count==DEPTH maps top to DEPTH-1 correctly.
  assign w_idx_wr   = r_count[AW-1:0];
  assign w_idx_top  = r_count[AW-1:0] - AW'(1);
  assign w_idx_next = r_count[AW-1:0] - AW'(2);

  assign w_full  = (r_count == PTRW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_two   = (r_count >= PTRW'(2));

  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_push_ok  = w_accept && (cmd == C_PUSH) && !w_full;
  assign w_push_err = w_accept && (cmd == C_PUSH) &&  w_full;
  assign w_pop_ok   = w_accept && (cmd == C_POP)  && !w_empty;
  assign w_pop_err  = w_accept && (cmd == C_POP)  &&  w_empty;
  assign w_alu_ok   = w_accept && (cmd == C_ALU)  &&  w_two;
  assign w_alu_err  = w_accept && (cmd == C_ALU)  && !w_two;
  assign w_wb       = (r_state == S_WB);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_alu_ok) w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_oper  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_accept && !w_alu_ok) || (r_state == S_EXEC);
      if (w_push_err) r_ovf <= 1'b1;
      if (w_pop_err || w_alu_err) r_unf <= 1'b1;
      if (w_push_ok) r_count <= r_count + PTRW'(1);
      else if (w_pop_ok || w_wb) r_count <= r_count - PTRW'(1);
      if (w_alu_ok) begin
        r_oper <= cmd_oper;
        r_a    <= r_mem[w_idx_top];
        r_b    <= r_mem[w_idx_next];
      end
    end
  end

  // Storage is deliberately unreset; the reset gate keeps an aborted writeback out of it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_push_ok) r_mem[w_idx_wr] <= push_data;
      else if (w_wb) r_mem[w_idx_next] <= alu_result;
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign alu_oper      = r_oper;
  assign alu_a         = r_a;
  assign alu_b         = r_b;
  assign top           = w_empty ? '0 : r_mem[w_idx_top];
  assign count         = r_count;
  assign done          = r_done;
  assign err_overflow  = r_ovf;
  assign err_underflow = r_unf;

endmodule
